// File: rtl/rv_decode_stage.sv
// RISC-V base-ISA decode stage: decodes on the input side, then holds results in an
// output register backed by a one-entry skid register so in_ready can be a flop.
module rv_decode_stage #(
  parameter int XLEN         = 32,
  parameter bit RV_C_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  dec_t        dec;
  dec_t        or_q;
  dec_t        sk_q;
  logic        or_v;
  logic        sk_v;
  logic [31:0] imm32;
  logic        accept;
  logic        or_free;

  // Handshake: a beat moves on a side in any cycle where valid and ready are both
  // high at the rising edge; out_* stays frozen while out_valid is high and out_ready low.
  assign accept  = in_valid & in_ready;
  assign or_free = ~or_v | out_ready;

  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    unique case (in_instr[6:0])
      7'b0110011:                                     dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.fmt = FMT_I;
      7'b0100011:                                     dec.fmt = FMT_S;
      7'b1100011:                                     dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
      7'b1101111:                                     dec.fmt = FMT_J;
      default:                                        dec.fmt = FMT_ILL;
    endcase
    if (RV_C_ILLEGAL && (in_instr[1:0] != 2'b11)) dec.fmt = FMT_ILL;
    dec.illegal = (dec.fmt == FMT_ILL);
    case (dec.fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm   = XLEN'($signed(imm32));
    dec.rd_we = (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (dec.rd != 5'd0);
  end

  // Skid occupancy alone gates new input, so in_ready is a pure flop output.
  assign in_ready = ~sk_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
      or_q <= '0;
      sk_q <= '0;
    end else if (flush) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
    end else if (or_free) begin
      if (sk_v) begin
        or_q <= sk_q;
        or_v <= 1'b1;
        sk_v <= 1'b0;
      end else if (accept) begin
        or_q <= dec;
        or_v <= 1'b1;
      end else begin
        or_v <= 1'b0;
      end
    end else if (accept) begin
      sk_q <= dec;
      sk_v <= 1'b1;
    end
  end

  assign out_valid   = or_v;
  assign out_pc      = or_q.pc;
  assign out_opcode  = or_q.opcode;
  assign out_rd      = or_q.rd;
  assign out_rs1     = or_q.rs1;
  assign out_rs2     = or_q.rs2;
  assign out_funct3  = or_q.funct3;
  assign out_funct7  = or_q.funct7;
  assign out_fmt     = or_q.fmt;
  assign out_imm     = or_q.imm;
  assign out_rd_we   = or_q.rd_we;
  assign out_illegal = or_q.illegal;

endmodule
